// File: rtl/ps2_pkg.sv
// ps2_pkg: shared states, abort codes and command bytes for the PS/2 host
// transmitter (and the keyboard receiver that shares the same lines).
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_CLK,
    ST_XFER,
    ST_WAIT_IDLE,
    ST_ABORT
  } ps2_state_t;

  // Abort reasons reported on err_code
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_NOCLK = 2'd1;
  localparam logic [1:0] ERR_FRAME = 2'd2;
  localparam logic [1:0] ERR_NOACK = 2'd3;

  // Common host commands and the device acknowledge byte
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Device falling-edge counts with a fixed meaning in the host-to-device frame
  localparam logic [3:0] EDGE_PARITY = 4'd9;
  localparam logic [3:0] EDGE_STOP   = 4'd10;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchroniser for one PS/2 line plus a falling-edge
// detector built from the synchronised level and its registered copy.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;
  logic prev;

  // Synchronise the pin and keep one delayed copy; idle-high reset avoids a false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= pin;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device. Runs the
// inhibit/request-to-send sequence, shifts start, data, parity and stop out
// on device clock falls, then checks the device's line-level acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ         = 50_000_000,
  parameter int INHIBIT_US       = 120,
  parameter int START_TIMEOUT_US = 15_000,
  parameter int FRAME_TIMEOUT_US = 2_000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam int CYC_PER_US     = CLK_FREQ / 1_000_000;
  localparam int INHIBIT_CYCLES = CYC_PER_US * INHIBIT_US;
  localparam int START_CYCLES   = CYC_PER_US * START_TIMEOUT_US;
  localparam int FRAME_CYCLES   = CYC_PER_US * FRAME_TIMEOUT_US;
  localparam int TMO_CYCLES     = (START_CYCLES > FRAME_CYCLES) ? START_CYCLES : FRAME_CYCLES;
  localparam int MAX_CYCLES     = (TMO_CYCLES > INHIBIT_CYCLES) ? TMO_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W          = $clog2(MAX_CYCLES + 1);

  ps2_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       edge_cnt;
  logic [3:0]       edge_nxt;
  logic [8:0]       shift;
  logic             clk_oe;
  logic             dat_oe;

  logic             clk_lvl;
  logic             clk_fall;
  logic             dat_lvl;
  logic             dat_fall_unused;

  logic             accept;
  logic             shift_en;
  logic             inhibit_end;
  logic             start_end;
  logic             frame_end;

  // Open-drain pads: pull low when enabled, otherwise float to the pull-up
  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

  ps2_line_sync u_clk_sync (
    .clk   (CLOCK),
    .rst   (RESET),
    .pin   (PS2_CLK),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk   (CLOCK),
    .rst   (RESET),
    .pin   (PS2_DAT),
    .level (dat_lvl),
    .fall  (dat_fall_unused)
  );

  assign accept      = tx_valid && tx_ready;
  assign edge_nxt    = edge_cnt + 4'd1;
  assign inhibit_end = (cnt == CNT_W'(INHIBIT_CYCLES - 1));
  assign start_end   = (cnt == CNT_W'(START_CYCLES - 1));
  assign frame_end   = (cnt == CNT_W'(FRAME_CYCLES - 1));

  // Bit 0 of the shift register is the next data/parity bit to put on the line
  assign shift_en = clk_fall &&
                    ((state == ST_WAIT_CLK) ||
                     ((state == ST_XFER) && (edge_nxt <= EDGE_PARITY)));

  // Frame shift register: loaded with {parity, data} on accept, advanced per driven bit
  always_ff @(posedge CLOCK) begin
    if (accept) begin
      shift <= {odd_parity(tx_data), tx_data};
    end else if (shift_en) begin
      shift <= {1'b1, shift[8:1]};
    end
  end

  // Control FSM: request-to-send, bit transfer on device clock falls, ack check
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      clk_oe   <= 1'b0;
      dat_oe   <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      cnt  <= cnt + CNT_W'(1);
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (accept) begin
            state    <= ST_INHIBIT;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            err_code <= ERR_NONE;
            edge_cnt <= '0;
            clk_oe   <= 1'b1;
          end
        end

        ST_INHIBIT: begin
          if (inhibit_end) begin
            state  <= ST_REQ;
            cnt    <= '0;
            dat_oe <= 1'b1;
          end
        end

        ST_REQ: begin
          // Data already low (start bit); releasing the clock hands it to the device
          state  <= ST_WAIT_CLK;
          cnt    <= '0;
          clk_oe <= 1'b0;
        end

        ST_WAIT_CLK: begin
          if (clk_fall) begin
            state    <= ST_XFER;
            cnt      <= '0;
            edge_cnt <= 4'd1;
            dat_oe   <= ~shift[0];
          end else if (start_end) begin
            state    <= ST_ABORT;
            cnt      <= '0;
            err_code <= ERR_NOCLK;
            err      <= 1'b1;
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
          end
        end

        ST_XFER: begin
          if (clk_fall) begin
            edge_cnt <= edge_nxt;
            if (edge_nxt <= EDGE_PARITY) begin
              dat_oe <= ~shift[0];
            end else if (edge_nxt == EDGE_STOP) begin
              dat_oe <= 1'b0;
            end else if (dat_lvl) begin
              // Eleventh fall with data still high: device did not acknowledge
              state    <= ST_ABORT;
              cnt      <= '0;
              err_code <= ERR_NOACK;
              err      <= 1'b1;
              clk_oe   <= 1'b0;
              dat_oe   <= 1'b0;
            end else begin
              state <= ST_WAIT_IDLE;
              cnt   <= '0;
            end
          end else if (frame_end) begin
            state    <= ST_ABORT;
            cnt      <= '0;
            err_code <= ERR_FRAME;
            err      <= 1'b1;
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_lvl && dat_lvl) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            done     <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end else if (frame_end) begin
            state    <= ST_ABORT;
            cnt      <= '0;
            err_code <= ERR_FRAME;
            err      <= 1'b1;
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
          end
        end

        ST_ABORT: begin
          // Lines were released and err raised on entry; finish the abort here
          state    <= ST_IDLE;
          cnt      <= '0;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          clk_oe   <= 1'b0;
          dat_oe   <= 1'b0;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model plus scoreboard for ps2_host_tx.
// Expected line bits and outcomes are queued when a byte is sent and
// consumed as the device model samples the line and the DUT pulses done/err.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_FREQ         = 1_000_000;
  localparam int INHIBIT_US       = 120;
  localparam int START_TIMEOUT_US = 5_000;
  localparam int FRAME_TIMEOUT_US = 2_000;
  localparam int INHIBIT_CYCLES   = CLK_FREQ / 1_000_000 * INHIBIT_US;
  localparam int START_CYCLES     = CLK_FREQ / 1_000_000 * START_TIMEOUT_US;
  localparam int FRAME_CYCLES     = CLK_FREQ / 1_000_000 * FRAME_TIMEOUT_US;
  localparam int HALF             = 40;  // 12.5 kHz device clock at 1 MHz

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  wire        ps2_clk;
  wire        ps2_dat;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  logic       exp_bits[$];
  logic [3:0] exp_out[$];   // {done, err, err_code}
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_acc   = 0;
  int         n_sent  = 0;

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ         (CLK_FREQ),
    .INHIBIT_US       (INHIBIT_US),
    .START_TIMEOUT_US (START_TIMEOUT_US),
    .FRAME_TIMEOUT_US (FRAME_TIMEOUT_US)
  ) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic pop_bit();
    if (exp_bits.size() != 0) return exp_bits.pop_front();
    return 1'bx;
  endfunction

  // Outcome and accept monitor, sampled on the falling clock edge
  always @(negedge clk) begin
    if (tx_valid && tx_ready) n_acc++;
    if (done || err) begin
      if (exp_out.size() == 0) check_eq("spurious_pulse", {done, err, err_code}, 4'b0000);
      else check_eq("outcome", {done, err, err_code}, exp_out.pop_front());
    end
  end

  // Queue the expected frame, issue the byte and check the request-to-send timing
  task automatic send(input logic [7:0] b, input bit hold);
    int ones;
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    exp_bits.push_back((ones % 2) == 0);
    exp_bits.push_back(1'b1);
    n_sent++;
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    if (hold) tx_data = 8'h12;
    else tx_valid = 1'b0;
    check_eq("clk_low_at_accept", ps2_clk, 1'b0);
    check_eq("busy_at_accept", busy, 1'b1);
    check_eq("ready_at_accept", tx_ready, 1'b0);
    tick(INHIBIT_CYCLES - 1);
    check_eq("dat_high_in_inhibit", ps2_dat, 1'b1);
    tick(1);
    check_eq("dat_low_req", ps2_dat, 1'b0);
    check_eq("clk_low_req", ps2_clk, 1'b0);
    tick(1);
    check_eq("clk_released", ps2_clk, 1'b1);
  endtask

  // Device model: samples host data on rising edges, optionally acks on edge 11
  task automatic device_run(input int n_fall, input bit ack, input bit drop_valid);
    int k;
    k = 0;
    while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && k < 400) begin
      tick(1);
      k++;
    end
    check_eq("rts_seen", (k < 400), 1'b1);
    check_eq("start_bit", ps2_dat, pop_bit());
    tick(20);
    for (int i = 1; i <= n_fall; i++) begin
      dev_clk_low = 1'b1;
      tick(HALF);
      dev_clk_low = 1'b0;
      if (i <= 10) check_eq($sformatf("bit%0d", i), ps2_dat, pop_bit());
      if (i == 10 && ack) dev_dat_low = 1'b1;
      if (i == 11 && drop_valid) tx_valid = 1'b0;
      tick(HALF);
      if (i == 11) dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_outcome(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_out.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, exp_out.size(), 0);
    exp_out.delete();
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tick(3);
    check_eq("rst_ready", tx_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_err_code", err_code, ERR_NONE);
    check_eq("rst_clk_line", ps2_clk, 1'b1);
    check_eq("rst_dat_line", ps2_dat, 1'b1);
    rst = 1'b0;
    tick(10);

    // Full frames with acknowledge: 0xED and parity edge values
    exp_out.push_back(4'b1000);
    send(CMD_SET_LEDS, 1'b0);
    device_run(11, 1'b1, 1'b0);
    wait_outcome("ed_outcome", 200);
    check_eq("ed_err_code", err_code, ERR_NONE);
    tick(10);
    exp_out.push_back(4'b1000);
    send(8'h00, 1'b0);
    device_run(11, 1'b1, 1'b0);
    wait_outcome("x00_outcome", 200);
    tick(10);
    exp_out.push_back(4'b1000);
    send(8'h01, 1'b0);
    device_run(11, 1'b1, 1'b0);
    wait_outcome("x01_outcome", 200);
    tick(10);

    // Device never clocks
    exp_out.push_back({2'b01, ERR_NOCLK});
    send(8'h3C, 1'b0);
    k = 0;
    while (err !== 1'b1 && k < START_CYCLES + 50) begin
      tick(1);
      k++;
    end
    check_eq("noclk_latency", k, START_CYCLES);
    check_eq("noclk_clk_released", ps2_clk, 1'b1);
    check_eq("noclk_dat_released", ps2_dat, 1'b1);
    wait_outcome("noclk_outcome", 20);
    exp_bits.delete();
    tick(10);

    // Device omits the acknowledge
    exp_out.push_back({2'b01, ERR_NOACK});
    send(CMD_ECHO, 1'b0);
    device_run(11, 1'b0, 1'b0);
    wait_outcome("noack_outcome", 200);
    tick(10);

    // Device stops clocking after 5 edges
    exp_out.push_back({2'b01, ERR_FRAME});
    send(8'hF3, 1'b0);
    device_run(5, 1'b1, 1'b0);
    wait_outcome("frame_outcome", FRAME_CYCLES + 100);
    check_eq("frame_err_code", err_code, ERR_FRAME);
    check_eq("frame_dat_released", ps2_dat, 1'b1);
    exp_bits.delete();
    tick(10);

    // tx_valid held (with different data) for the whole frame
    exp_out.push_back(4'b1000);
    send(CMD_SET_LEDS, 1'b1);
    device_run(11, 1'b1, 1'b1);
    wait_outcome("hold_outcome", 200);
    tick(20);
    check_eq("hold_no_reaccept_clk", ps2_clk, 1'b1);
    check_eq("hold_ready", tx_ready, 1'b1);
    check_eq("hold_err_code", err_code, ERR_NONE);

    // Reset at device edge 6 while the host drives data low
    send(8'h55, 1'b0);
    device_run(5, 1'b1, 1'b0);
    dev_clk_low = 1'b1;
    tick(HALF);
    dev_clk_low = 1'b0;
    tick(5);
    check_eq("pre_rst_dat_driven", ps2_dat, 1'b0);
    rst = 1'b1;
    tick(1);
    check_eq("midrst_dat_released", ps2_dat, 1'b1);
    check_eq("midrst_clk_released", ps2_clk, 1'b1);
    check_eq("midrst_ready", tx_ready, 1'b1);
    check_eq("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    exp_bits.delete();
    tick(20);

    // Fresh command after the reset completes normally
    exp_out.push_back(4'b1000);
    send(CMD_RESET, 1'b0);
    device_run(11, 1'b1, 1'b0);
    wait_outcome("ff_outcome", 200);
    check_eq("ff_err_code", err_code, ERR_NONE);
    tick(10);

    check_eq("accept_count", n_acc, n_sent);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
